// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding,
// word/header geometry and the helper that decides which states accept bytes.
package boot_loader_pkg;

   typedef enum logic [2:0] {
      HDR0,
      HDR1,
      COLLECT,
      WRITE,
      CHK,
      DONE,
      ERR
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_STRIDE    = 4;
   localparam int HDR_BYTE_W     = 8;
   localparam int COUNT_W        = 16;
   localparam int WORD_W         = 32;

   // States that take a stream byte; in_ready is registered from this.
   function automatic logic is_accepting(input state_t s);
      return (s == HDR0) || (s == HDR1) || (s == COLLECT) || (s == CHK);
   endfunction

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Little-endian byte-to-word shift register: first byte ends up in [7:0],
// the fourth in [31:24]. word_full flags the shift that completes a word.
module word_assembler
   import boot_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_en,
   input  logic [7:0]        byte_in,
   input  logic              clear,
   output logic [WORD_W-1:0] word_out,
   output logic              word_full
);

   logic [1:0] byte_cnt;

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         word_out <= '0;
         byte_cnt <= '0;
      end else if (shift_en) begin
         word_out <= {byte_in, word_out[WORD_W-1:8]};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   // High in the cycle whose edge shifts in the last byte of a word.
   assign word_full = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/boot_loader.sv
// Byte-stream program loader: writes count words into memory, then releases
// the CPU. Define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic        mem_wr,
   output logic        cpu_reset,
   output logic        boot_done,
   output logic        boot_err,
   output logic [15:0] words_loaded
);

   localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_WORDS);

   state_t              state;
   state_t              state_next;
   logic [COUNT_W-1:0]  count;
   logic [COUNT_W-1:0]  hdr_count;
   logic [COUNT_W-1:0]  words_next;
   logic                take;
   logic                shift_en;
   logic                clear;
   logic                word_full;
   logic [WORD_W-1:0]   word;

`ifdef BOOT_LOADER_CHECKSUM_EN
   localparam state_t AFTER_LAST = CHK;
   logic [7:0] xor_acc;
`else
   localparam state_t AFTER_LAST = DONE;
`endif

   assign take       = in_valid & in_ready;
   assign shift_en   = take && (state == COLLECT);
   assign clear      = (state == HDR0) || (state == HDR1);
   assign hdr_count  = {in_data, count[HDR_BYTE_W-1:0]};
   assign words_next = words_loaded + 16'd1;

   word_assembler u_assembler (
      .clk       (clk),
      .reset     (reset),
      .shift_en  (shift_en),
      .byte_in   (in_data),
      .clear     (clear),
      .word_out  (word),
      .word_full (word_full)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= HDR0;
         in_ready <= 1'b0;
      end else begin
         state    <= state_next;
         in_ready <= is_accepting(state_next);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         HDR0:    if (take) state_next = HDR1;
         HDR1: begin
            if (take) begin
               if (hdr_count == '0 || hdr_count > MAX_COUNT) state_next = ERR;
               else                                          state_next = COLLECT;
            end
         end
         COLLECT: if (word_full) state_next = WRITE;
         WRITE:   state_next = (words_next == count) ? AFTER_LAST : COLLECT;
`ifdef BOOT_LOADER_CHECKSUM_EN
         CHK:     if (take) state_next = (in_data == xor_acc) ? DONE : ERR;
`else
         // Unreachable without the checksum option; fail safe.
         CHK:     state_next = ERR;
`endif
         DONE:    state_next = DONE;
         ERR:     state_next = ERR;
         default: state_next = ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count        <= '0;
         words_loaded <= '0;
      end else begin
         if (take && state == HDR0) count[HDR_BYTE_W-1:0]       <= in_data;
         if (take && state == HDR1) count[COUNT_W-1:HDR_BYTE_W] <= in_data;
         if (state == WRITE)        words_loaded                <= words_next;
      end
   end

`ifdef BOOT_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!reset)        xor_acc <= '0;
      else if (shift_en) xor_acc <= xor_acc ^ in_data;
   end
`endif

   // Address wraps modulo 2^32 by construction.
   assign mem_addr  = BASE_ADDR + (32'(words_loaded) * 32'(WORD_STRIDE));
   assign mem_wd    = word;
   assign mem_wr    = (state == WRITE);
   assign cpu_reset = (state != DONE);
   assign boot_done = (state == DONE);
   assign boot_err  = (state == ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: two instances (base 0x0 and 0x100) share
// one input stream; a write monitor pops expected {addr,data} per instance.
module tb_boot_loader;

   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;

   logic        in_ready0, mem_wr0, cpu_reset0, boot_done0, boot_err0;
   logic [31:0] mem_addr0, mem_wd0;
   logic [15:0] words_loaded0;
   logic        in_ready1, mem_wr1, cpu_reset1, boot_done1, boot_err1;
   logic [31:0] mem_addr1, mem_wd1;
   logic [15:0] words_loaded1;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int wr_prev = 0;
   int wr_last = 0;
   logic prev_wr0 = 1'b0;
   logic prev_wr1 = 1'b0;
   logic [63:0] e0, e1;
   logic [63:0] exp_q0[$];
   logic [63:0] exp_q1[$];
   logic [7:0]  stream_q[$];
   int          widx = 0;
   logic [7:0]  cks = 8'h00;

   boot_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(64)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready0), .mem_addr(mem_addr0), .mem_wd(mem_wd0), .mem_wr(mem_wr0),
      .cpu_reset(cpu_reset0), .boot_done(boot_done0), .boot_err(boot_err0),
      .words_loaded(words_loaded0)
   );

   boot_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(64)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready1), .mem_addr(mem_addr1), .mem_wd(mem_wd1), .mem_wr(mem_wr1),
      .cpu_reset(cpu_reset1), .boot_done(boot_done1), .boot_err(boot_err1),
      .words_loaded(words_loaded1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #300000;
      $display("FAIL watchdog observed=still_running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (mem_wr0) begin
         chk("wr0_in_ready", 64'(in_ready0), 64'd0);
         chk("wr0_cpu_reset", 64'(cpu_reset0), 64'd1);
         chk("wr0_pulse", 64'(prev_wr0), 64'd0);
         if (exp_q0.size() == 0) chk("wr0_unexpected", 64'(exp_q0.size()), 64'd1);
         else begin
            e0 = exp_q0.pop_front();
            chk("wr0_addr", 64'(mem_addr0), 64'(e0[63:32]));
            chk("wr0_data", 64'(mem_wd0), 64'(e0[31:0]));
         end
         wr_prev = wr_last;
         wr_last = cyc;
      end
      prev_wr0 = mem_wr0;
   end

   always @(negedge clk) begin
      if (mem_wr1) begin
         chk("wr1_in_ready", 64'(in_ready1), 64'd0);
         if (exp_q1.size() == 0) chk("wr1_unexpected", 64'(exp_q1.size()), 64'd1);
         else begin
            e1 = exp_q1.pop_front();
            chk("wr1_addr", 64'(mem_addr1), 64'(e1[63:32]));
            chk("wr1_data", 64'(mem_wd1), 64'(e1[31:0]));
         end
         chk("wr1_pulse", 64'(prev_wr1), 64'd0);
      end
      prev_wr1 = mem_wr1;
   end

   // Called at a negedge; returns at a negedge with reset released.
   task automatic do_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready0), 64'd0);
      chk("rst_mem_addr0", 64'(mem_addr0), 64'(BASE0));
      chk("rst_mem_addr1", 64'(mem_addr1), 64'(BASE1));
      chk("rst_mem_wd", 64'(mem_wd0), 64'd0);
      chk("rst_mem_wr", 64'(mem_wr0), 64'd0);
      chk("rst_cpu_reset", 64'(cpu_reset0), 64'd1);
      chk("rst_boot_done", 64'(boot_done0), 64'd0);
      chk("rst_boot_err", 64'(boot_err0), 64'd0);
      chk("rst_words", 64'(words_loaded0), 64'd0);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bp);
      logic was;
      was = 1'b0;
      if (bp) begin
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            @(negedge clk);
         end
      end
      in_valid = 1'b1;
      in_data = b;
      for (int n = 0; n < 50 && !was; n++) begin
         was = in_ready0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!was) chk("accept_timeout", 64'(was), 64'd1);
   endtask

   task automatic start_stream(input logic [15:0] n);
      stream_q.delete();
      widx = 0;
      cks = 8'h00;
      stream_q.push_back(n[7:0]);
      stream_q.push_back(n[15:8]);
   endtask

   task automatic add_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         stream_q.push_back(w[8*k +: 8]);
         cks = cks ^ w[8*k +: 8];
      end
      exp_q0.push_back({BASE0 + 32'(4 * widx), w});
      exp_q1.push_back({BASE1 + 32'(4 * widx), w});
      widx++;
   endtask

   task automatic end_stream();
`ifdef BOOT_LOADER_CHECKSUM_EN
      stream_q.push_back(cks);
`endif
   endtask

   task automatic send_stream(input bit bp);
      foreach (stream_q[i]) send_byte(stream_q[i], bp);
   endtask

   task automatic wait_done();
      for (int n = 0; n < 30 && !boot_done0; n++) @(negedge clk);
      chk("done0", 64'(boot_done0), 64'd1);
      chk("done1", 64'(boot_done1), 64'd1);
      chk("done_cpu_reset0", 64'(cpu_reset0), 64'd0);
      chk("done_cpu_reset1", 64'(cpu_reset1), 64'd0);
      chk("done_err", 64'(boot_err0), 64'd0);
      chk("done_words0", 64'(words_loaded0), 64'(widx));
      chk("done_words1", 64'(words_loaded1), 64'(widx));
      chk("done_q0_empty", 64'(exp_q0.size()), 64'd0);
      chk("done_q1_empty", 64'(exp_q1.size()), 64'd0);
   endtask

   task automatic expect_err(input string tag);
      chk({tag, "_err"}, 64'(boot_err0), 64'd1);
      chk({tag, "_cpu_reset"}, 64'(cpu_reset0), 64'd1);
      chk({tag, "_done"}, 64'(boot_done0), 64'd0);
      in_valid = 1'b1;
      in_data = 8'hA5;
      repeat (3) begin
         chk({tag, "_in_ready"}, 64'(in_ready0), 64'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Basic load at full rate.
      start_stream(16'd2);
      add_word(32'h4433_2211);
      add_word(32'hDDCC_BBAA);
      end_stream();
      send_stream(1'b0);
`ifndef BOOT_LOADER_CHECKSUM_EN
      chk("last_write_visible", 64'(mem_wr0), 64'd1);
      chk("last_write_cpu_reset", 64'(cpu_reset0), 64'd1);
      @(negedge clk);
      chk("release_latency", 64'(cpu_reset0), 64'd0);
`endif
      wait_done();
      chk("word_rate", 64'(wr_last - wr_prev), 64'd5);

      // Bytes offered after DONE are refused.
      in_valid = 1'b1;
      in_data = 8'h5A;
      repeat (4) begin
         chk("post_done_in_ready", 64'(in_ready0), 64'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("post_done_words", 64'(words_loaded0), 64'd2);
      chk("post_done_still_done", 64'(boot_done0), 64'd1);

      // Header rejection: zero count, and one above the maximum.
      do_reset();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      expect_err("hdr_zero");
      do_reset();
      send_byte(8'h41, 1'b0);
      send_byte(8'h00, 1'b0);
      expect_err("hdr_over");

      // Exactly MAX_WORDS is accepted.
      do_reset();
      send_byte(8'h40, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("hdr_max_err", 64'(boot_err0), 64'd0);
      chk("hdr_max_ready", 64'(in_ready0), 64'd1);

      // Reset after two payload bytes, then a clean reload.
      do_reset();
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      do_reset();
      start_stream(16'd1);
      add_word(32'hCAFE_F00D);
      end_stream();
      send_stream(1'b0);
      wait_done();

      // Random back-pressure over three random words.
      do_reset();
      start_stream(16'd3);
      for (int i = 0; i < 3; i++) add_word($urandom());
      end_stream();
      send_stream(1'b1);
      wait_done();

`ifdef BOOT_LOADER_CHECKSUM_EN
      do_reset();
      start_stream(16'd1);
      add_word(32'h0804_0201);
      stream_q.push_back(8'h0F);
      send_stream(1'b0);
      wait_done();
      do_reset();
      start_stream(16'd1);
      add_word(32'h0804_0201);
      stream_q.push_back(8'h0E);
      send_stream(1'b0);
      @(negedge clk);
      expect_err("cks_bad");
      chk("cks_bad_q_empty", 64'(exp_q0.size()), 64'd0);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
